// File: rtl/gin_pkg.sv
// Shared defaults for the column crossbar: payload/tag widths, column count,
// buffer depth and the broadcast tag value.
package gin_pkg;
    localparam int GIN_DATA_WIDTH    = 64;
    localparam int GIN_COL_TAG_WIDTH = 4;
    localparam int GIN_NUM_OF_COLS   = 14;
    localparam int GIN_FIFO_DEPTH    = 2;
    localparam int GIN_BCAST_EN      = 1;

    localparam logic [GIN_COL_TAG_WIDTH-1:0] GIN_BCAST_TAG = '1;
endpackage

// File: rtl/gin_col_fifo.sv
// Per-column output buffer: power-of-two ring with a registered occupancy
// count. The head is forced to zero while empty.
module gin_col_fifo #(
    parameter int DATA_WIDTH = 64,
    parameter int FIFO_DEPTH = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  push,
    input  logic [DATA_WIDTH-1:0] din,
    input  logic                  pop_rdy,
    output logic [DATA_WIDTH-1:0] dout,
    output logic                  valid,
    output logic                  full
);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;

    logic [FIFO_DEPTH-1:0][DATA_WIDTH-1:0] mem_q;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          pop;

    always_comb begin
        valid    = (count_q != '0);
        full     = (count_q == CW'(FIFO_DEPTH));
        pop      = valid && pop_rdy;
        dout     = valid ? mem_q[rd_ptr_q] : '0;
        wr_ptr_d = push ? PW'(wr_ptr_q + 1'b1) : wr_ptr_q;
        rd_ptr_d = pop  ? PW'(rd_ptr_q + 1'b1) : rd_ptr_q;
        count_d  = count_q;
        if (push && !pop)
            count_d = count_q + 1'b1;
        else if (pop && !push)
            count_d = count_q - 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: the head is masked until a write lands.
    always_ff @(posedge clk) begin
        if (push)
            mem_q[wr_ptr_q] <= din;
    end
endmodule

// File: rtl/gin_xbus_mc.sv
// Multicast column bus: one upstream word is pushed atomically into every
// column whose scanned-in ID matches the tag (or all columns on broadcast).
module gin_xbus_mc
    import gin_pkg::*;
#(
    parameter int DATA_WIDTH    = GIN_DATA_WIDTH,
    parameter int COL_TAG_WIDTH = GIN_COL_TAG_WIDTH,
    parameter int NUM_OF_COLS   = GIN_NUM_OF_COLS,
    parameter int FIFO_DEPTH    = GIN_FIFO_DEPTH,
    parameter int BCAST_EN      = GIN_BCAST_EN
) (
    input  logic                              link_clk,
    input  logic                              reset,
    input  logic [DATA_WIDTH-1:0]             data_in,
    input  logic [COL_TAG_WIDTH-1:0]          col_tag,
    input  logic                              enable_in,
    output logic                              ready_out,
    output logic [NUM_OF_COLS*DATA_WIDTH-1:0] data_out,
    output logic [NUM_OF_COLS-1:0]            enable_out,
    input  logic [NUM_OF_COLS-1:0]            ready_in,
    input  logic                              se_id,
    input  logic                              si_id,
    output logic                              so_id,
    output logic                              drop_out
);
    localparam int CHAIN_W = NUM_OF_COLS * COL_TAG_WIDTH;
    localparam logic [COL_TAG_WIDTH-1:0] BCAST_TAG = '1;

    logic [NUM_OF_COLS-1:0][COL_TAG_WIDTH-1:0] col_id_q, col_id_d;
    logic [CHAIN_W-1:0]     chain;
    logic [NUM_OF_COLS-1:0] match, full, push;
    logic                   bcast, accept;
    logic                   drop_q, drop_d;

    always_comb begin
        match = '0;
        bcast = (BCAST_EN != 0) && (col_tag == BCAST_TAG);
        for (int i = 0; i < NUM_OF_COLS; i++)
            match[i] = bcast || (col_tag == col_id_q[i]);
        // Stall the whole word if any target is full: no partial multicast.
        ready_out = reset && !se_id && ((match & full) == '0);
        accept    = enable_in && ready_out;
        push      = accept ? match : '0;
        drop_d    = accept && (match == '0);

        // The IDs form one long shift chain, column 0 LSB first.
        chain    = col_id_q;
        col_id_d = col_id_q;
        if (se_id)
            col_id_d = {chain[CHAIN_W-2:0], si_id};
    end

    always_ff @(posedge link_clk or negedge reset) begin
        if (!reset) begin
            col_id_q <= '0;
            drop_q   <= 1'b0;
        end else begin
            col_id_q <= col_id_d;
            drop_q   <= drop_d;
        end
    end

    assign so_id    = col_id_q[NUM_OF_COLS-1][COL_TAG_WIDTH-1];
    assign drop_out = drop_q;

    for (genvar i = 0; i < NUM_OF_COLS; i++) begin : g_col
        gin_col_fifo #(
            .DATA_WIDTH (DATA_WIDTH),
            .FIFO_DEPTH (FIFO_DEPTH)
        ) u_fifo (
            .clk     (link_clk),
            .rst_n   (reset),
            .push    (push[i]),
            .din     (data_in),
            .pop_rdy (ready_in[i]),
            .dout    (data_out[i*DATA_WIDTH +: DATA_WIDTH]),
            .valid   (enable_out[i]),
            .full    (full[i])
        );
    end
endmodule

// File: tb/tb_gin_xbus_mc.sv
// Bench for gin_xbus_mc: per-column queue model plus an ID bit-chain model,
// directed scenarios followed by a randomized run.
module tb_gin_xbus_mc;
    localparam int DW = 64, TW = 4, NC = 14, DEPTH = 2;
    localparam int OW = NC * DW, CHN = NC * TW;

    logic            link_clk = 1'b0;
    logic            reset;
    logic [DW-1:0]   data_in;
    logic [TW-1:0]   col_tag;
    logic            enable_in;
    logic            ready_out;
    logic [OW-1:0]   data_out;
    logic [NC-1:0]   enable_out;
    logic [NC-1:0]   ready_in;
    logic            se_id, si_id, so_id, drop_out;

    gin_xbus_mc #(.DATA_WIDTH(DW), .COL_TAG_WIDTH(TW), .NUM_OF_COLS(NC),
                  .FIFO_DEPTH(DEPTH), .BCAST_EN(1)) dut (
        .link_clk   (link_clk),
        .reset      (reset),
        .data_in    (data_in),
        .col_tag    (col_tag),
        .enable_in  (enable_in),
        .ready_out  (ready_out),
        .data_out   (data_out),
        .enable_out (enable_out),
        .ready_in   (ready_in),
        .se_id      (se_id),
        .si_id      (si_id),
        .so_id      (so_id),
        .drop_out   (drop_out)
    );

    always #5 link_clk = ~link_clk;

    int errs = 0, nchk = 0;

    task automatic chk(input string tag, input logic [OW-1:0] act, input logic [OW-1:0] exp);
        nchk++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0h want %0h", tag, act, exp);
        end
    endtask

    // Reference state
    logic [DW-1:0] mq[NC][$];
    bit            chain_m[CHN];
    bit            drop_m;
    logic          last_rdy;

    function automatic logic [TW-1:0] mid(input int i);
        logic [TW-1:0] v;
        for (int b = 0; b < TW; b++) v[b] = chain_m[i*TW + b];
        return v;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < NC; i++) mq[i].delete();
        for (int p = 0; p < CHN; p++) chain_m[p] = 1'b0;
        drop_m = 1'b0;
    endtask

    // Called at a falling edge; checks state, drives one cycle, advances model.
    task automatic cyc(input logic en, input logic [TW-1:0] tag, input logic [DW-1:0] d,
                       input logic [NC-1:0] rdy, input logic se, input logic si);
        logic [NC-1:0] en_e, m;
        logic [OW-1:0] dat_e, mask;
        logic          rdy_e;
        int            nm;
        en_e = '0; dat_e = '0; mask = '0; m = '0;
        for (int i = 0; i < NC; i++)
            if (mq[i].size() > 0) begin
                en_e[i] = 1'b1;
                dat_e[i*DW +: DW] = mq[i][0];
                mask[i*DW +: DW] = '1;
            end
        chk("enable_out", OW'(enable_out), OW'(en_e));
        chk("data_out", data_out & mask, dat_e);
        chk("drop_out", OW'(drop_out), OW'(drop_m));
        chk("so_id", OW'(so_id), OW'(chain_m[CHN-1]));

        enable_in = en; col_tag = tag; data_in = d; ready_in = rdy; se_id = se; si_id = si;
        #1;
        rdy_e = !se; nm = 0;
        for (int i = 0; i < NC; i++) begin
            m[i] = (tag == mid(i)) || (tag == 4'hF);
            if (m[i]) begin
                nm++;
                if (mq[i].size() >= DEPTH) rdy_e = 1'b0;
            end
        end
        chk("ready_out", OW'(ready_out), OW'(rdy_e));
        last_rdy = ready_out;

        for (int i = 0; i < NC; i++)
            if (mq[i].size() > 0 && rdy[i]) void'(mq[i].pop_front());
        if (en && rdy_e)
            for (int i = 0; i < NC; i++)
                if (m[i]) mq[i].push_back(d);
        drop_m = en && rdy_e && (nm == 0);
        if (se) begin
            for (int p = CHN-1; p > 0; p--) chain_m[p] = chain_m[p-1];
            chain_m[0] = si;
        end
        @(negedge link_clk);
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) cyc(1'b0, '0, '0, '1, 1'b0, 1'b0);
    endtask

    // Shift the far end of the chain first so each column lands in place.
    task automatic scan_load(input logic [NC-1:0][TW-1:0] ids);
        for (int k = 0; k < CHN; k++) begin
            int p;
            p = CHN - 1 - k;
            cyc(1'b0, '0, '0, '1, 1'b1, ids[p/TW][p%TW]);
        end
    endtask

    logic [NC-1:0][TW-1:0] ids;
    logic [NC-1:0]         rmask;

    initial begin
        reset = 1'b0; enable_in = 1'b1; col_tag = '0; data_in = '1;
        ready_in = '0; se_id = 1'b0; si_id = 1'b1;
        model_reset();
        #2;
        chk("rst_enable_out", OW'(enable_out), '0);
        chk("rst_ready_out", OW'(ready_out), '0);
        chk("rst_data_out", data_out, '0);
        chk("rst_drop_so", OW'({drop_out, so_id}), '0);
        @(negedge link_clk);
        reset = 1'b1;

        // First accept right after release; all IDs are 0, so tag 0 hits every column
        cyc(1'b1, 4'h0, 64'h1111_2222_3333_4444, '0, 1'b0, 1'b0);
        chk("first_accept", OW'(enable_out), OW'(14'h3FFF));
        idle(2);

        // Scan in col_id[i] = i and route tag 5
        for (int i = 0; i < NC; i++) ids[i] = TW'(i);
        scan_load(ids);
        cyc(1'b1, 4'h5, 64'hDEAD_BEEF_0000_0005, '0, 1'b0, 1'b0);
        chk("route5_en", OW'(enable_out), OW'(14'h0020));
        chk("route5_data", OW'(data_out[5*DW +: DW]), OW'(64'hDEAD_BEEF_0000_0005));
        idle(1);

        // Backpressure on column 4
        rmask = ~(14'h1 << 4);
        cyc(1'b1, 4'h4, 64'hB1, rmask, 1'b0, 1'b0);
        cyc(1'b1, 4'h4, 64'hB2, rmask, 1'b0, 1'b0);
        cyc(1'b1, 4'h4, 64'hB3, rmask, 1'b0, 1'b0);
        chk("bp_stall", OW'(last_rdy), '0);
        cyc(1'b1, 4'h4, 64'hB3, '1, 1'b0, 1'b0);
        chk("bp_no_pop_credit", OW'(last_rdy), '0);
        cyc(1'b1, 4'h4, 64'hB3, rmask, 1'b0, 1'b0);
        chk("bp_resume", OW'(last_rdy), OW'(1'b1));
        chk("bp_head", OW'(data_out[4*DW +: DW]), OW'(64'hB2));
        idle(3);

        // Broadcast reaches every column exactly once; unmatched tag drops
        cyc(1'b1, 4'hF, 64'hCAFE, '0, 1'b0, 1'b0);
        chk("bcast_all", OW'(enable_out), OW'(14'h3FFF));
        cyc(1'b1, 4'hE, 64'hEEEE, '1, 1'b0, 1'b0);
        chk("bcast_once", OW'(enable_out), '0);
        chk("drop_pulse", OW'(drop_out), OW'(1'b1));
        idle(1);
        chk("drop_one_cycle", OW'(drop_out), '0);

        // Multicast to columns 2 and 7
        for (int i = 0; i < NC; i++) ids[i] = TW'(i);
        ids[2] = 4'h3; ids[7] = 4'h3; ids[3] = 4'h0;
        scan_load(ids);
        cyc(1'b1, 4'h3, 64'hA5, '0, 1'b0, 1'b0);
        chk("mc_en", OW'(enable_out), OW'(14'h0084));
        chk("mc_data2", OW'(data_out[2*DW +: DW]), OW'(64'hA5));
        chk("mc_data7", OW'(data_out[7*DW +: DW]), OW'(64'hA5));
        idle(1);

        // Randomized traffic, including occasional scan shifts
        for (int k = 0; k < 600; k++)
            cyc(($urandom_range(0, 3) != 0), TW'($urandom_range(0, 15)),
                {$urandom, $urandom}, NC'($urandom | $urandom),
                ($urandom_range(0, 19) == 0), 1'($urandom));

        // Reset with two words buffered in every column
        cyc(1'b1, 4'hF, 64'h5A1, '0, 1'b0, 1'b0);
        cyc(1'b1, 4'hF, 64'h5A2, '0, 1'b0, 1'b0);
        chk("pre_rst_full", OW'(enable_out), OW'(14'h3FFF));
        #2 reset = 1'b0;
        #1;
        model_reset();
        chk("mid_rst_enable_out", OW'(enable_out), '0);
        chk("mid_rst_data_out", data_out, '0);
        chk("mid_rst_ready_drop_so", OW'({ready_out, drop_out, so_id}), '0);
        @(negedge link_clk);
        reset = 1'b1;
        cyc(1'b1, 4'h0, 64'h77, '0, 1'b0, 1'b0);
        chk("post_rst_en", OW'(enable_out), OW'(14'h3FFF));
        chk("post_rst_no_stale", OW'(data_out[0 +: DW]), OW'(64'h77));
        idle(2);
        chk("post_rst_drained", OW'(enable_out), '0);

        $display("Result: errors=%0d of %0d checks", errs, nchk);
        $finish;
    end
endmodule

// File: doc/gin_xbus_mc.md
GIN_XBUS_MC -- requirements
Module: gin_xbus_mc

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 64, meaning payload width.
REQ-002 The block SHALL have parameter COL_TAG_WIDTH, default 4, meaning column tag / column ID width.
REQ-003 The block SHALL have parameter NUM_OF_COLS, default 14, meaning column count.
REQ-004 The block SHALL have parameter FIFO_DEPTH, default 2, meaning per-column output buffer entries (power of two, at least 2).
REQ-005 The block SHALL have parameter BCAST_EN, default 1, meaning that the all-ones tag is broadcast when set.
REQ-006 The block SHALL have port link_clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-007 The block SHALL have port reset, input, 1 bit: asynchronous, active-low reset.
REQ-008 The block SHALL have port data_in, input, DATA_WIDTH: bus payload.
REQ-009 The block SHALL have port col_tag, input, COL_TAG_WIDTH: destination column tag.
REQ-010 The block SHALL have port enable_in, input, 1 bit: upstream valid.
REQ-011 The block SHALL have port ready_out, output, 1 bit: upstream ready (aggregated).
REQ-012 The block SHALL have port data_out, output, NUM_OF_COLS x DATA_WIDTH: per-column FIFO head.
REQ-013 The block SHALL have port enable_out, output, NUM_OF_COLS: per-column valid (FIFO non-empty).
REQ-014 The block SHALL have port ready_in, input, NUM_OF_COLS: per-column downstream ready.
REQ-015 The block SHALL have port se_id, input, 1 bit: ID scan enable.
REQ-016 The block SHALL have port si_id, input, 1 bit: ID scan in.
REQ-017 The block SHALL have port so_id, output, 1 bit: ID scan out.
REQ-018 The block SHALL have port drop_out, output, 1 bit: one-cycle pulse when an accepted word matched no column.

Function
REQ-019 Each column SHALL hold a COL_TAG_WIDTH-bit col_id register; column i matches when col_tag == col_id[i], or when BCAST_EN=1 and col_tag is all-ones.
REQ-020 ready_out SHALL be 1 only when se_id=0 and every matching column's FIFO occupancy < FIFO_DEPTH; occupancy is the registered count, and same-cycle pops SHALL NOT be credited.
REQ-021 A word SHALL be accepted on an edge where enable_in=1 and ready_out=1; it SHALL be pushed atomically into every matching column's FIFO; partial multicast is forbidden.
REQ-022 An accepted word with zero matches SHALL be discarded, and drop_out SHALL be 1 on the following cycle.
REQ-023 A word accepted at edge t SHALL appear with enable_out[i]=1 after edge t (latency 1).
REQ-024 Each column SHALL pop on an edge where enable_out[i]=1 and ready_in[i]=1, independently of other columns.
REQ-025 A simultaneous push and pop on a non-full FIFO SHALL leave occupancy unchanged and preserve order.
REQ-026 Throughput SHALL be 1 word/cycle per column while ready_in[i]=1.
REQ-027 While se_id=1, each edge SHALL shift the ID chain: col_id[0] <= {col_id[0][W-2:0], si_id}; col_id[i] <= {col_id[i][W-2:0], col_id[i-1][W-1]}.
REQ-028 so_id SHALL equal col_id[NUM_OF_COLS-1][W-1].
REQ-029 While se_id=1, no push SHALL occur; pops SHALL continue.
REQ-030 Occupancy counters SHALL be $clog2(FIFO_DEPTH)+1 bits; read and write pointers SHALL wrap modulo FIFO_DEPTH.

Reset
REQ-031 While reset=0, asynchronously: all col_id=0, all FIFOs empty, enable_out=0, ready_out=0, drop_out=0, data_out=0, so_id=0.
REQ-032 Assertion mid-transfer SHALL discard all buffered words; the first accept SHALL be possible on the first edge after release.

Structure
REQ-033 A shared package gin_pkg SHALL hold the default widths, column count, and the broadcast-tag constant.
REQ-034 One sub-module, gin_col_fifo (FIFO plus occupancy count), SHALL be instantiated per column via generate.

Verification
REQ-035 Scan: 56 shift cycles loading col_id[i]=i (cols 0..13) -> col_tag=5 delivers only to column 5, and so_id follows the chain MSB.
REQ-036 Multicast: col_id[2]=col_id[7]=3, send tag 3 data 0xA5 -> enable_out[2] and enable_out[7] high next cycle, both with data 0xA5.
REQ-037 Backpressure: col 4 ready_in=0, 3 words to tag 4 (DEPTH=2) -> 2 accepted, ready_out=0 for the third; one pop -> third accepted next edge.
REQ-038 Broadcast: tag 0xF, BCAST_EN=1, with any col_id all-ones -> all 14 columns receive the word once; unmatched tag 0xE -> drop_out pulse.
REQ-039 Reset mid-burst: reset=0 with 2 words buffered -> enable_out=0 immediately; after release, no stale words appear.
